// File: rtl/md5_pkg.sv
// Shared MD5 constants: sine table, rotate amounts, IV words and the FSM state type.
package md5_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K [0:63] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [4:0] S [0:63] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/md5_step.sv
// One combinational MD5 step: round function, message word select, rotate and shuffle.
module md5_step
  import md5_pkg::*;
(
  input  logic [5:0]   idx,
  input  logic [31:0]  a,
  input  logic [31:0]  b,
  input  logic [31:0]  c,
  input  logic [31:0]  d,
  input  logic [511:0] block,
  output logic [31:0]  a_new,
  output logic [31:0]  b_new,
  output logic [31:0]  c_new,
  output logic [31:0]  d_new
);

  logic [3:0]  i;
  logic [3:0]  g;
  logic [31:0] f;
  logic [31:0] m;
  logic [31:0] sum;
  logic [31:0] t;

  assign i = idx[3:0];

  // Round-dependent boolean function and message word index; 4-bit math gives mod 16.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    f = '0;
    g = i;
    case (idx[5:4])
      2'd0: begin f = (b & c) | (~b & d); g = i;                  end
      2'd1: begin f = (b & d) | (c & ~d); g = i * 4'd5 + 4'd1;    end
      2'd2: begin f = b ^ c ^ d;          g = i * 4'd3 + 4'd5;    end
      default: begin f = c ^ (b | ~d);    g = i * 4'd7;           end
    endcase
  end

  // Accumulate, rotate, then shift the working words along.
  always_comb begin
    m     = block[{g, 5'd0} +: 32];
    sum   = a + f + K[idx] + m;
    t     = rotl32(sum, S[idx]);
    a_new = d;
    b_new = b + t;
    c_new = b;
    d_new = c;
  end

endmodule

// File: rtl/md5_block_engine.sv
// Iterative MD5 compression: STEPS_PER_CYCLE chained steps per clock, start/busy/done handshake.
module md5_block_engine
  import md5_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         use_iv,
  input  logic [511:0] indata,
  input  logic [127:0] link_var,
  output logic         busy,
  output logic         done,
  output logic [127:0] digest
);

  localparam bit LEGAL = (STEPS_PER_CYCLE == 1) || (STEPS_PER_CYCLE == 2) ||
                         (STEPS_PER_CYCLE == 4) || (STEPS_PER_CYCLE == 8) ||
                         (STEPS_PER_CYCLE == 16);

  generate
    if (!LEGAL) begin : g_illegal_steps
      $error("md5_block_engine: STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam logic [5:0] LAST_CNT = 6'(64 - STEPS_PER_CYCLE);
  localparam logic [5:0] STEP_INC = 6'(STEPS_PER_CYCLE);

  state_t       state, state_next;
  logic [5:0]   cnt;
  logic [511:0] block;
  logic [31:0]  a, b, c, d;
  logic [31:0]  sa, sb, sc, sd;
  logic         accept;
  logic         last;
  logic [127:0] chain_in;

  logic [31:0] ca [0:STEPS_PER_CYCLE];
  logic [31:0] cb [0:STEPS_PER_CYCLE];
  logic [31:0] cc [0:STEPS_PER_CYCLE];
  logic [31:0] cd [0:STEPS_PER_CYCLE];

  assign chain_in = use_iv ? {IV_D, IV_C, IV_B, IV_A} : link_var;

  assign ca[0] = a;
  assign cb[0] = b;
  assign cc[0] = c;
  assign cd[0] = d;

  generate
    for (genvar k = 0; k < STEPS_PER_CYCLE; k++) begin : g_step
      md5_step u_step (
        .idx   (cnt + 6'(k)),
        .a     (ca[k]),
        .b     (cb[k]),
        .c     (cc[k]),
        .d     (cd[k]),
        .block (block),
        .a_new (ca[k+1]),
        .b_new (cb[k+1]),
        .c_new (cc[k+1]),
        .d_new (cd[k+1])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic plus the accept / last-edge strobes and busy.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Block, working, save registers and counter; feed-forward add on the last edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      block  <= '0;
      {d, c, b, a}     <= '0;
      {sd, sc, sb, sa} <= '0;
      digest <= '0;
      done   <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        cnt              <= '0;
        block            <= indata;
        {d, c, b, a}     <= chain_in;
        {sd, sc, sb, sa} <= chain_in;
      end else if (state == RUN) begin
        cnt <= cnt + STEP_INC;
        a   <= ca[STEPS_PER_CYCLE];
        b   <= cb[STEPS_PER_CYCLE];
        c   <= cc[STEPS_PER_CYCLE];
        d   <= cd[STEPS_PER_CYCLE];
        if (last) begin
          digest <= {sd + cd[STEPS_PER_CYCLE], sc + cc[STEPS_PER_CYCLE],
                     sb + cb[STEPS_PER_CYCLE], sa + ca[STEPS_PER_CYCLE]};
        end
      end
    end
  end

endmodule

// File: tb/tb_md5_block_engine.sv
// Directed-vector bench for md5_block_engine: known MD5 digests, latency, handshake and reset.
module tb_md5_block_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, use_iv;
  logic [511:0] indata;
  logic [127:0] link_var;
  logic         busy, done;
  logic [127:0] digest;

  logic         start_m, use_iv_m;
  logic [511:0] indata_m;
  logic [127:0] link_var_m;
  logic         busy2, done2, busy4, done4, busy16, done16;
  logic [127:0] digest2, digest4, digest16;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] EMPTY_DIG = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
  localparam logic [127:0] ABC_DIG   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};
  localparam logic [127:0] AA_DIG    = {32'h67733f79, 32'h63034a5a, 32'h4971b580, 32'hd4424801};

  md5_block_engine #(.STEPS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .use_iv(use_iv), .indata(indata),
    .link_var(link_var), .busy(busy), .done(done), .digest(digest));
  md5_block_engine #(.STEPS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_m), .use_iv(use_iv_m), .indata(indata_m),
    .link_var(link_var_m), .busy(busy2), .done(done2), .digest(digest2));
  md5_block_engine #(.STEPS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_m), .use_iv(use_iv_m), .indata(indata_m),
    .link_var(link_var_m), .busy(busy4), .done(done4), .digest(digest4));
  md5_block_engine #(.STEPS_PER_CYCLE(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start_m), .use_iv(use_iv_m), .indata(indata_m),
    .link_var(link_var_m), .busy(busy16), .done(done16), .digest(digest16));

  function automatic logic [511:0] make_block(input logic [31:0] w0, input logic [31:0] w14);
    logic [511:0] blk;
    blk            = '0;
    blk[31:0]      = w0;
    blk[14*32 +: 32] = w14;
    return blk;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic iv, input logic [511:0] blk, input logic [127:0] lv);
    start    = 1'b1;
    use_iv   = iv;
    indata   = blk;
    link_var = lv;
    tick();
    start    = 1'b0;
    indata   = '1;
    link_var = '1;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  logic [511:0] empty_blk, abc_blk, aa1_blk, aa2_blk;
  int           lat, lat2, lat4, lat16, ndone, first, busy_gaps;
  logic         seen_busy, seen_done;
  logic [127:0] seen_digest;

  initial begin
    empty_blk = make_block(32'h00000080, 32'h0);
    abc_blk   = make_block(32'h80636261, 32'h00000018);
    aa1_blk   = {16{32'h61616161}};
    aa2_blk   = make_block(32'h00000080, 32'h00000200);

    rst = 1'b1; start = 1'b0; use_iv = 1'b0; indata = '0; link_var = '0;
    start_m = 1'b0; use_iv_m = 1'b0; indata_m = '0; link_var_m = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state.
    check("reset_busy",   128'(busy),  128'd0);
    check("reset_done",   128'(done),  128'd0);
    check("reset_digest", digest,      128'd0);

    // Idle with start low for 100 cycles.
    seen_busy = 1'b0; seen_done = 1'b0; seen_digest = '0;
    for (int k = 0; k < 100; k++) begin
      tick();
      seen_busy   = seen_busy | busy;
      seen_done   = seen_done | done;
      seen_digest = seen_digest | digest;
    end
    check("idle_busy",   128'(seen_busy), 128'd0);
    check("idle_done",   128'(seen_done), 128'd0);
    check("idle_digest", seen_digest,     128'd0);

    // Empty string, with busy/done timing across the whole run.
    issue(1'b1, empty_blk, '0);
    busy_gaps = 0; lat = -1;
    for (int k = 1; k <= 70; k++) begin
      if (k < 64 && !busy) busy_gaps++;
      tick();
      if (done && lat < 0) begin
        lat = k;
        check("empty_busy_in_done", 128'(busy), 128'd0);
      end
    end
    check("empty_busy_held", 128'(busy_gaps), 128'd0);
    check("empty_latency",   128'(lat),       128'd64);
    check("empty_digest",    digest,          EMPTY_DIG);

    // "abc" on the one-step engine.
    issue(1'b1, abc_blk, '0);
    wait_done(200, lat);
    check("abc1_latency", 128'(lat), 128'd64);
    check("abc1_digest",  digest,    ABC_DIG);

    // "abc" on the 2-, 4- and 16-step engines together.
    start_m = 1'b1; use_iv_m = 1'b1; indata_m = abc_blk; link_var_m = '1;
    tick();
    start_m = 1'b0; indata_m = '1;
    lat2 = -1; lat4 = -1; lat16 = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done2  && lat2  < 0) lat2  = k;
      if (done4  && lat4  < 0) lat4  = k;
      if (done16 && lat16 < 0) lat16 = k;
    end
    check("abc2_latency",  128'(lat2),  128'd32);
    check("abc4_latency",  128'(lat4),  128'd16);
    check("abc16_latency", 128'(lat16), 128'd4);
    check("abc2_digest",   digest2,     ABC_DIG);
    check("abc4_digest",   digest4,     ABC_DIG);
    check("abc16_digest",  digest16,    ABC_DIG);

    // Two-block message of 64 'a' bytes, second block issued in the done cycle.
    issue(1'b1, aa1_blk, '0);
    wait_done(200, lat);
    check("aa_blk1_latency", 128'(lat), 128'd64);
    issue(1'b0, aa2_blk, digest);
    check("aa_no_idle_busy", 128'(busy), 128'd1);
    wait_done(200, lat);
    check("aa_blk2_latency", 128'(lat), 128'd64);
    check("aa_digest",       digest,    AA_DIG);

    // Start pulses during RUN are ignored.
    issue(1'b1, empty_blk, '0);
    ndone = 0; first = -1;
    for (int k = 1; k <= 90; k++) begin
      if (k == 5 || k == 30) begin
        start = 1'b1; use_iv = 1'b1; indata = abc_blk;
      end
      tick();
      start = 1'b0; indata = '1;
      if (done) begin
        ndone++;
        if (first < 0) first = k;
      end
    end
    check("ignore_done_count", 128'(ndone), 128'd1);
    check("ignore_done_cycle", 128'(first), 128'd64);
    check("ignore_digest",     digest,      EMPTY_DIG);

    // Reset in the middle of RUN.
    issue(1'b1, abc_blk, '0);
    for (int k = 0; k < 40; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy",   128'(busy), 128'd0);
    check("midrst_done",   128'(done), 128'd0);
    check("midrst_digest", digest,     128'd0);
    ndone = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (done) ndone++;
    end
    check("midrst_no_done", 128'(ndone), 128'd0);
    issue(1'b1, abc_blk, '0);
    wait_done(200, lat);
    check("postrst_latency", 128'(lat), 128'd64);
    check("postrst_digest",  digest,    ABC_DIG);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md5_block_engine.md
# md5_block_engine

Iterative MD5 compression engine. It takes one 512-bit message block and a 128-bit chaining value, runs all 64 MD5 steps across rounds 1–4, and returns the feed-forward-added 128-bit chaining value. It generalises the team's single-step round datapath in two ways: the number of steps per clock is a parameter, and a start/busy/done handshake drives a multi-block hash. It sits between the message padder and the digest output register.

## Interface
- `STEPS_PER_CYCLE`, default 1: MD5 steps evaluated per clock. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- `clk` — input, 1 bit: the single clock. All state changes on the rising edge.
- `rst` — input, 1 bit: synchronous, active-high reset.
- `start` — input, 1 bit: request to process `indata`. Sampled only in IDLE.
- `use_iv` — input, 1 bit, sampled with `start`.
  - 1: use the standard IV A=67452301, B=efcdab89, C=98badcfe, D=10325476.
  - 0: use `link_var`.
- `indata` — input, 512 bits: the message block. Word i is `indata[32i +: 32]`, little-endian as MD5 defines.
- `link_var` — input, 128 bits: the chaining input. A=[31:0], B=[63:32], C=[95:64], D=[127:96].
- `busy` — output, 1 bit: high while in RUN.
- `done` — output, 1 bit: one-cycle pulse meaning `digest` has just been updated.
- `digest` — output, 128 bits: the result, packed the same way as `link_var`. Holds its value until the next `done`.

## Operation
- States: IDLE and RUN. `N = 64 / STEPS_PER_CYCLE`.
- IDLE, `start`=1:
  - Latch `indata` into the block register.
  - Latch the chaining value (IV or `link_var`) into both the working registers A/B/C/D and the save registers.
  - Clear the step counter `cnt` (6 bits) and go to RUN.
- RUN, each edge: apply steps `cnt` .. `cnt+STEPS_PER_CYCLE-1` combinationally in order, then `cnt += STEPS_PER_CYCLE`.
- One step with index j (round r = j[5:4], i = j[3:0]):
  - Round 0: F = (B&C)|(~B&D), g = i.
  - Round 1: F = (B&D)|(C&~D), g = (5i+1) mod 16.
  - Round 2: F = B^C^D, g = (3i+5) mod 16.
  - Round 3: F = C^(B|~D), g = (7i) mod 16.
  - T = rotl32(A + F + K[j] + M[g], S[j]).
  - Update: (A, B, C, D) ← (D, B+T, B, C).
  - All additions are modulo 2^32, with no carry-out.
- Last RUN edge (`cnt` = 64 − STEPS_PER_CYCLE):
  - `digest` ← per-word sum of the save registers and the updated A/B/C/D (mod 2^32).
  - `done` ← 1, state ← IDLE.
- `start` in RUN is ignored; it is not queued.
- `start` in the cycle where `done`=1 (state is IDLE) is accepted, so blocks issue back to back.
- `indata` and `link_var` are don't-care except on the accepting edge.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `digest`=0, `cnt`=0. Working, save and block registers are all 0.
- Latency: start accepted at edge E0 → `done` and the new `digest` are visible after edge E_N (N cycles later). For `STEPS_PER_CYCLE`=1 that is 64 cycles.
- `busy` is high from after E0 through the cycle before E_N's output; it is low in the `done` cycle.
- Throughput: one block per N cycles with back-to-back `start`.
- `rst` mid-RUN: on the next edge, return to IDLE with all reset values. No `done` is issued and `digest` is cleared.
- `rst` and `start` together: reset wins.
- Combinational path per cycle: STEPS_PER_CYCLE chained steps. The counter wraps 64 → 0 only in the transition to IDLE.

## Structure
- Package `md5_pkg` holds:
  - `K[0:63]`, the 32-bit sine constants.
  - `S[0:63]`, the 5-bit rotate amounts: round 0 {7,12,17,22}, round 1 {5,9,14,20}, round 2 {4,11,16,23}, round 3 {6,10,15,21}, each repeated.
  - The IV constants and the state enum.
- Sub-module `md5_step`: purely combinational, taking step index, A/B/C/D and the 512-bit block, and producing the next A/B/C/D. It is instantiated STEPS_PER_CYCLE times in a generate chain.
- The top level holds the FSM, counter, registers and feed-forward adders.

## Test plan
- Empty string: `use_iv`=1, `indata` word0=00000080, all other words 0.
  - → after 64 cycles `done`=1 and `digest` words A..D = d98c1dd4, 04b2008f, 980980e9, 7e42f8ec (bytes d41d8cd98f00b204e9800998ecf8427e).
- "abc": word0=80636261, word14=00000018, all others 0.
  - → `digest` bytes 900150983cd24fb0d6963f7d28e17f72.
  - Repeat for STEPS_PER_CYCLE = 2, 4 and 16, checking latency = 32, 16 and 4 cycles.
- Two-block message of 64 'a' bytes: block 1 with `use_iv`=1, then block 2 (padding) with `use_iv`=0 and `link_var`=previous `digest`, issued in the `done` cycle.
  - → final bytes 014842d480b571495a4a0363793f7367.
  - No idle cycle between the two blocks.
- `start` pulsed at cycles 5 and 30 of RUN → ignored; single `done` at cycle 64; `digest` matches the first block.
- `rst` asserted at RUN cycle 40 → next cycle `busy`=0 and `digest`=0; no `done` afterwards; a fresh `start` produces the correct result.
- After reset, `start` held low for 100 cycles → `busy`, `done` and `digest` stay 0.
